// File: rtl/pipe_run_controller.sv
// Run/stall/flush sequencer: start, COM handshake with the interpreter, END drain.
// Optional handshake timeout: define PIPE_RUN_CTRL_TIMEOUT_EN.
module pipe_run_controller #(
  parameter int COM_WORDS = 8,
  parameter int DRAIN     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [3:0]                   Id,
  input  logic                         BranchTaken,
  input  logic                         ComAck,
  output logic                         ComReq,
  output logic [$clog2(COM_WORDS)-1:0] ComIdx,
  output logic                         StallF,
  output logic                         StallD,
  output logic                         FlushD,
  output logic                         FlushE,
  output logic                         Busy,
  output logic                         Done,
  output logic                         Error
);

  localparam int IW = $clog2(COM_WORDS);
  localparam int DW = $clog2(DRAIN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  if (COM_WORDS < 2) begin : g_chk_words
    $error("COM_WORDS must be >= 2");
  end
  if (DRAIN < 1) begin : g_chk_drain
    $error("DRAIN must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_chk_to
    $error("TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_COM_REQ,
    S_COM_REL,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [DW-1:0] drain_cnt, drain_n;
  logic          skip, skip_n;

  logic is_com, is_end;
  assign is_com = (Id == 4'b0001);
  assign is_end = (Id == 4'b0010);

`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
  logic [TW-1:0] to_cnt, to_n;
  logic          waiting;

  // Stuck in a handshake phase: neither ack edge has arrived yet.
  assign waiting = (state == S_COM_REQ && !ComAck) ||
                   (state == S_COM_REL &&  ComAck);
  assign Error   = (state == S_ERROR);
`else
  assign Error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      skip      <= 1'b0;
`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      drain_cnt <= drain_n;
      skip      <= skip_n;
`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
      to_cnt    <= to_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    drain_n = drain_cnt;
    skip_n  = skip;
`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
    to_n    = to_cnt;
`endif
    ComReq  = 1'b0;
    StallF  = 1'b1;
    StallD  = 1'b1;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        StallF = 1'b0;
        StallD = 1'b0;
        Busy   = 1'b1;
        // After a COM the held COM is still in decode: kill it once.
        FlushD = skip | BranchTaken;
        FlushE = BranchTaken;
        skip_n = 1'b0;
        if (!BranchTaken) begin
          if (is_com && !skip) begin
            state_n = S_COM_REQ;
`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
            to_n    = '0;
`endif
          end else if (is_end) begin
            state_n = S_DRAIN;
            drain_n = '0;
          end
        end
      end
      S_COM_REQ: begin
        ComReq = 1'b1;
        Busy   = 1'b1;
        if (ComAck) begin
          state_n = S_COM_REL;
`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
          to_n    = '0;
`endif
        end
      end
      S_COM_REL: begin
        Busy = 1'b1;
        if (!ComAck) begin
`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
          to_n = '0;
`endif
          if (idx == IW'(COM_WORDS - 1)) begin
            state_n = S_RUN;
            idx_n   = '0;
            skip_n  = 1'b1;
          end else begin
            state_n = S_COM_REQ;
            idx_n   = idx + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        StallD = 1'b0;
        FlushD = 1'b1;
        Busy   = 1'b1;
        if (drain_cnt == DW'(DRAIN - 1)) state_n = S_DONE;
        else drain_n = drain_cnt + 1'b1;
      end
      S_DONE: begin
        Done = 1'b1;
      end
      S_ERROR: begin
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
    if (waiting) begin
      if (to_cnt == TW'(TIMEOUT - 1)) state_n = S_ERROR;
      else to_n = to_cnt + 1'b1;
    end
`endif
  end

  assign ComIdx = idx;

endmodule

// File: tb/tb_pipe_run_controller.sv
// Scoreboard bench for pipe_run_controller against a phase-level reference model.
module tb_pipe_run_controller;

  localparam int CW = 8;
  localparam int DR = 4;
  localparam int TO = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_REQ  = 2;
  localparam int M_REL  = 3;
  localparam int M_DRN  = 4;
  localparam int M_DONE = 5;
  localparam int M_ERR  = 6;

  logic       clk = 1'b0;
  logic       reset, start, BranchTaken, ComAck;
  logic [3:0] Id;
  logic       ComReq, StallF, StallD, FlushD, FlushE, Busy, Done, Error;
  logic [2:0] ComIdx;

  pipe_run_controller #(
    .COM_WORDS(CW),
    .DRAIN(DR),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Id(Id),
    .BranchTaken(BranchTaken),
    .ComAck(ComAck),
    .ComReq(ComReq),
    .ComIdx(ComIdx),
    .StallF(StallF),
    .StallD(StallD),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .Busy(Busy),
    .Done(Done),
    .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req;
    logic [2:0] idx;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int   mode = M_IDLE;
  int   word = 0;
  int   drained = 0;
  int   waited = 0;
  bit   skip = 0;
  bit   known = 0;

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {ComReq, ComIdx, StallF, StallD, FlushD, FlushE, Busy, Done, Error};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got=%b required=%b", $time, a, e);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [3:0] i,
                      input logic b, input logic a);
    exp_t e;
    reset = r; start = s; Id = i; BranchTaken = b; ComAck = a;
    if (known) begin
      e = '0;
      e.idx = 3'(word);
      e.sf = 1'b1;
      e.sd = 1'b1;
      case (mode)
        M_RUN: begin
          e.sf = 0; e.sd = 0; e.busy = 1;
          e.fd = skip || b; e.fe = b;
        end
        M_REQ:  begin e.req = 1; e.busy = 1; end
        M_REL:  e.busy = 1;
        M_DRN:  begin e.sd = 0; e.fd = 1; e.busy = 1; end
        M_DONE: e.done = 1;
        M_ERR:  e.err = 1;
        default: ;
      endcase
      q.push_back(e);
    end
    if (r) begin
      mode = M_IDLE; word = 0; drained = 0; waited = 0; skip = 0;
      known = 1;
    end else begin
      case (mode)
        M_IDLE: if (s) mode = M_RUN;
        M_RUN: begin
          if (!b && i == 4'd1 && !skip) begin mode = M_REQ; waited = 0; end
          else if (!b && i == 4'd2) begin mode = M_DRN; drained = 0; end
          skip = 0;
        end
        M_REQ: begin
          if (a) begin mode = M_REL; waited = 0; end
          else waited++;
        end
        M_REL: begin
          if (!a) begin
            waited = 0;
            word++;
            if (word == CW) begin word = 0; skip = 1; mode = M_RUN; end
            else mode = M_REQ;
          end else waited++;
        end
        M_DRN: begin
          drained++;
          if (drained == DR) mode = M_DONE;
        end
        default: ;
      endcase
`ifdef PIPE_RUN_CTRL_TIMEOUT_EN
      if ((mode == M_REQ || mode == M_REL) && waited == TO) mode = M_ERR;
`endif
    end
    @(posedge clk); #1;
  endtask

  task automatic do_word();
    step(0, 0, 4'd1, 0, 0);
    step(0, 0, 4'd1, 0, 0);
    step(0, 0, 4'd1, 0, 1);
    step(0, 0, 4'd1, 0, 0);
  endtask

  initial begin
    logic [3:0] others [6];
    others = '{4'd0, 4'd12, 4'd13, 4'd14, 4'd5, 4'd9};
    @(posedge clk); #1;

    // Reset, start, NOP stream
    step(1, 0, 4'd0, 0, 0);
    step(1, 0, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 0);
    step(0, 1, 4'd0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 4'd0, 0, 0);

    // Full COM block, then skip cycle with COM still decoded
    step(0, 0, 4'd1, 0, 0);
    for (int w = 0; w < CW; w++) do_word();
    step(0, 0, 4'd1, 0, 0);
    step(0, 0, 4'd0, 0, 0);

    // END under a taken branch, then real END and drain
    step(0, 0, 4'd2, 1, 0);
    step(0, 0, 4'd2, 0, 0);
    for (int k = 0; k < DR; k++) step(0, 0, 4'd2, k[0], 1);
    step(0, 1, 4'd0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 4'd1, 0, 0);

    // Reset mid-handshake at word 3
    step(1, 0, 4'd0, 0, 0);
    step(0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd1, 0, 0);
    for (int w = 0; w < 3; w++) do_word();
    step(0, 0, 4'd1, 0, 0);
    step(1, 0, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 0);

    // Interpreter never acknowledges
    step(0, 1, 4'd0, 0, 0);
    step(0, 0, 4'd1, 0, 0);
    for (int k = 0; k < 1000; k++) step(0, 0, 4'd0, 0, 0);

    // Randomized traffic
    step(1, 0, 4'd0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      int p;
      logic [3:0] id;
      p = int'($urandom % 100);
      if (p < 10) id = 4'd1;
      else if (p < 13) id = 4'd2;
      else id = others[$urandom % 6];
      step(($urandom % 250) == 0, ($urandom % 20) == 0, id,
           ($urandom % 6) == 0, ($urandom % 2) == 1);
    end

    step(1, 0, 4'd0, 0, 0);
    step(0, 0, 4'd0, 0, 0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue left=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
